mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the pipelined CPU's memory bus. It provides word-addressed RAM through one instruction read port (port 0) and one data read/write port (port 1), with byte write enables. It also decodes a small MMIO window holding a programmable interval timer (PIT), a UART transmit FIFO with serializer, and an interrupt-pending register that drives the CPU's `interrupts` input. It sits at top level between the CPU and the board pins.

## Interface
Parameters:
- `RAM_WORDS`, 65536: RAM depth in 32-bit words, power of 2. Addresses at or above `RAM_WORDS` and outside MMIO read 0 and ignore writes.
- `INIT_FILE`, "": hex image loaded into RAM at elaboration when non-empty.
- `MMIO_BASE`, 18'h3FF00: word address of the first MMIO register.
- `TX_DEPTH`, 16: UART FIFO depth, power of 2, at least 2.
- `BAUD_DIV`, 868: clk cycles per UART bit, at least 2.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `clk_en`, in, 1: CPU advance strobe; gates all write and PIT side effects.
- `mem_read0_addr`, in, 18: instruction word address.
- `mem_read0_data`, out, 32: instruction read data.
- `mem_re`, in, 1: port 1 read enable.
- `mem_read1_addr`, in, 18: data read word address.
- `mem_read1_data`, out, 32: data read data.
- `mem_we`, in, 4: byte write enables; bit i controls bits [8i+7:8i].
- `mem_write_addr`, in, 18: write word address.
- `mem_write_data`, in, 32: write data.
- `ext_irq`, in, 14: external interrupt levels, latched into pending bits [15:2].
- `interrupts`, out, 16: pending interrupt vector, level.
- `uart_tx`, out, 1: serial TX line, idle high.

## Operation
- RAM reads, port 0: every cycle, registered. MMIO and out-of-range addresses return 0.
- RAM reads, port 1: registered when `mem_re`=1. When `mem_re`=0 the output holds its previous value.
- Writes: act when `clk_en`=1 and `mem_we`≠0. RAM writes only the enabled bytes.
- Read-during-write to the same address returns old data on both ports (read-first).
- MMIO writes use the full `mem_write_data` word whenever any `mem_we` bit is set. MMIO reads have no side effects.
- MMIO registers (offset from `MMIO_BASE`):
  - +0 TX (write-only): push `data[7:0]` into the FIFO. If the FIFO is full, the byte is dropped and the sticky `ovf` flag is set.
  - +1 STATUS: read returns `{20'b0, ovf, count[6:0], busy, full, empty}` padded to 32 bits. Any write clears `ovf`.
  - +2 PIT_RELOAD: write loads reload and count from `data[31:0]`; the value 0 disables the PIT.
  - +3 PIT_COUNT: read-only current count.
  - +4 PENDING: read returns the pending vector. Write is write-1-to-clear on bits [1:0]. Bits [15:2] mirror the registered `ext_irq` and are not clearable.
- PIT: on each `clk_en` cycle with reload≠0, if count==1 then count←reload and pending[0]←1; otherwise count←count−1.
- UART serializer FSM:
  - States IDLE→START→DATA→STOP→IDLE. Each state holds `BAUD_DIV` clk cycles; DATA holds 8 bits, LSB first.
  - IDLE pops the FIFO when it is non-empty. The serializer is free-running on `clk` and is not gated by `clk_en`.
  - `busy` = state≠IDLE.
  - pending[1] is set when STOP completes and the FIFO is empty.
- Simultaneous events:
  - FIFO push and pop in the same cycle: both occur, count unchanged. Push when full with a pop that same cycle is accepted.
  - PIT_RELOAD write in the same cycle as an expiry: the write wins and pending[0] is not set.
  - Pending clear in the same cycle as a set: set wins.

## Timing
- Read latency is 1 cycle: an address presented at edge N gives data valid after edge N+1.
- A write at edge N is visible to a read issued at edge N+1.
- `interrupts` = pending register; asserted 1 cycle after the set condition.
- `ext_irq` passes through a 2-flop synchronizer, so bits [15:2] lag by 2 cycles.
- First start bit is driven 1 cycle after the push edge when the serializer is idle. One byte takes 10×`BAUD_DIV` cycles.
- Reset values:
  - Both read data outputs 0; `interrupts` 0; `uart_tx` 1.
  - FIFO empty, `ovf` 0, PIT reload and count 0, FSM IDLE.
  - RAM contents are unchanged by reset.
- Reset mid-byte aborts the frame: `uart_tx`=1 on the next cycle and queued bytes are discarded.

## Configuration
- `MEM_RESPONDER_UART_EN` defined: UART FIFO, serializer, and pending[1] are present.
- Undefined:
  - TX writes are ignored; STATUS reads 0.
  - `uart_tx` is tied to 1; pending[1] is constant 0.
  - RAM, PIT, and ext_irq behaviour are unchanged.

## Structure
- Package `mem_responder_pkg` holds:
  - MMIO offset constants (`MMIO_TX`, `MMIO_STATUS`, `MMIO_PIT_RELOAD`, `MMIO_PIT_COUNT`, `MMIO_PENDING`);
  - STATUS bit positions;
  - the UART state enum `uart_state_t`.
- One sub-module, `uart_tx_serializer`, contains the FIFO and the FSM. It is instantiated only under `MEM_RESPONDER_UART_EN`.

## Test plan
- Byte-enable write then read: write 0xAABBCCDD to 0x100 with we=4'b1111, then 0x11223344 with we=4'b0101 → port 1 reads 0xAA22CC44 one cycle after issue; port 0 reads the same value.
- Read-first and gating:
  - Same-cycle write 0x5 and read at 0x200 (prior value 0x0) → read returns 0x0, the next read returns 0x5.
  - A write with `clk_en`=0 leaves the RAM unchanged.
- PIT: write reload 3 with `clk_en` always high → pending[0] rises 3 cycles later and `interrupts`=16'h0001. Writing PENDING with 0x1 clears it; the next expiry occurs 3 cycles after that.
- UART, `BAUD_DIV`=4:
  - Push 0x55 → `uart_tx` shows 0,1,0,1,0,1,0,1,0,1 at 4 cycles per bit.
  - pending[1] sets after the stop bit.
  - `TX_DEPTH`+2 rapid pushes → STATUS.ovf=1.
- `ext_irq`=14'h0001 → `interrupts`=16'h0004 after 3 cycles. A PENDING write of 0xFFFF does not clear bit 2.
- Reset mid-frame: `uart_tx`=1 and STATUS.empty=1 on the next cycle; a previously written RAM word still reads back intact.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared MMIO map, STATUS layout and UART state type for mem_responder.
package mem_responder_pkg;

   localparam logic [2:0] MMIO_TX         = 3'd0;
   localparam logic [2:0] MMIO_STATUS     = 3'd1;
   localparam logic [2:0] MMIO_PIT_RELOAD = 3'd2;
   localparam logic [2:0] MMIO_PIT_COUNT  = 3'd3;
   localparam logic [2:0] MMIO_PENDING    = 3'd4;
   localparam int         MMIO_SPAN       = 8;

   localparam int ST_EMPTY     = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_BUSY      = 2;
   localparam int ST_COUNT_LSB = 3;
   localparam int ST_COUNT_W   = 7;
   localparam int ST_OVF       = 10;

   typedef enum logic [1:0] {
      UART_IDLE,
      UART_START,
      UART_DATA,
      UART_STOP
   } uart_state_t;

endpackage

// File: rtl/mem_responder_uart_tx_serializer.sv
// UART transmit FIFO plus 8N1 serializer; each bit lasts BAUD_DIV clocks, LSB first.
module uart_tx_serializer
   import mem_responder_pkg::*;
#(
   parameter int TX_DEPTH = 16,
   parameter int BAUD_DIV = 868
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [7:0]            push_data,
   input  logic                  clr_ovf,
   output logic                  tx,
   output logic                  busy,
   output logic                  empty,
   output logic                  full,
   output logic                  ovf,
   output logic [ST_COUNT_W-1:0] count,
   output logic                  done
);

   localparam int PW = $clog2(TX_DEPTH);
   localparam int BW = $clog2(BAUD_DIV);

   logic [7:0]    fifo_mem [TX_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   fill;
   logic          pop, push_ok, bit_end;

   uart_state_t   state, state_nx;
   logic [BW-1:0] baud, baud_nx;
   logic [2:0]    bit_idx, bit_nx;
   logic [7:0]    shreg, shreg_nx;

   assign empty   = (fill == '0);
   assign full    = (fill == (PW+1)'(TX_DEPTH));
   // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
   assign push_ok = push && (!full || pop);
   assign count   = ST_COUNT_W'(fill);
   assign busy    = (state != UART_IDLE);
   assign bit_end = (baud == BW'(BAUD_DIV - 1));

   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PW'(1);
         if (pop)     rd_ptr <= rd_ptr + PW'(1);
         if (push_ok && !pop)      fill <= fill + (PW+1)'(1);
         else if (!push_ok && pop) fill <= fill - (PW+1)'(1);
         if (push && !push_ok) ovf <= 1'b1;
         else if (clr_ovf)     ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= UART_IDLE;
         baud    <= '0;
         bit_idx <= '0;
      end else begin
         state   <= state_nx;
         baud    <= baud_nx;
         bit_idx <= bit_nx;
      end
      shreg <= shreg_nx;
   end

   always_comb begin
      state_nx = state;
      baud_nx  = baud;
      bit_nx   = bit_idx;
      shreg_nx = shreg;
      pop      = 1'b0;
      done     = 1'b0;
      tx       = 1'b1;
      case (state)
         UART_IDLE: begin
            if (!empty) begin
               pop      = 1'b1;
               shreg_nx = fifo_mem[rd_ptr];
               baud_nx  = '0;
               state_nx = UART_START;
            end
         end
         UART_START: begin
            tx = 1'b0;
            if (bit_end) begin
               baud_nx  = '0;
               bit_nx   = '0;
               state_nx = UART_DATA;
            end else begin
               baud_nx = baud + BW'(1);
            end
         end
         UART_DATA: begin
            tx = shreg[0];
            if (bit_end) begin
               baud_nx  = '0;
               shreg_nx = {1'b0, shreg[7:1]};
               bit_nx   = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_nx = UART_STOP;
            end else begin
               baud_nx = baud + BW'(1);
            end
         end
         UART_STOP: begin
            if (bit_end) begin
               baud_nx  = '0;
               state_nx = UART_IDLE;
               done     = empty;
            end else begin
               baud_nx = baud + BW'(1);
            end
         end
         default: state_nx = UART_IDLE;
      endcase
   end

endmodule

// File: rtl/mem_responder.sv
// Dual-port word RAM with MMIO PIT, pending-interrupt register and optional UART TX.
// The UART block is built only when MEM_RESPONDER_UART_EN is defined.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int          RAM_WORDS = 65536,
   parameter string       INIT_FILE = "",
   parameter logic [17:0] MMIO_BASE = 18'h3FF00,
   parameter int          TX_DEPTH  = 16,
   parameter int          BAUD_DIV  = 868
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clk_en,
   input  logic [17:0] mem_read0_addr,
   output logic [31:0] mem_read0_data,
   input  logic        mem_re,
   input  logic [17:0] mem_read1_addr,
   output logic [31:0] mem_read1_data,
   input  logic [3:0]  mem_we,
   input  logic [17:0] mem_write_addr,
   input  logic [31:0] mem_write_data,
   input  logic [13:0] ext_irq,
   output logic [15:0] interrupts,
   output logic        uart_tx
);

   localparam int AW = $clog2(RAM_WORDS);

   function automatic logic in_mmio(input logic [17:0] a);
      return (a >= MMIO_BASE) && ((a - MMIO_BASE) < 18'(MMIO_SPAN));
   endfunction

   function automatic logic in_ram(input logic [17:0] a);
      return ({14'b0, a} < 32'(RAM_WORDS)) && !in_mmio(a);
   endfunction

   logic [31:0] ram [RAM_WORDS];
   logic [31:0] ram_q0, ram_q1, mmio_q1, mmio_rdata, status_word;
   logic        hit0, ram_hit1, mmio_hit1;
   logic        wr, wr_ram, wr_mmio, reload_wr, pend_wr, pit_fire;
   logic [2:0]  w_off, r_off;
   logic [31:0] pit_reload, pit_count;
   logic [13:0] irq_s1, irq_s2;
   logic        pend0, pend1;
   logic        u_busy, u_empty, u_full, u_ovf;
   logic [ST_COUNT_W-1:0] u_count;

   assign wr        = clk_en && (mem_we != 4'b0);
   assign wr_ram    = wr && in_ram(mem_write_addr);
   assign wr_mmio   = wr && in_mmio(mem_write_addr);
   assign w_off     = 3'(mem_write_addr - MMIO_BASE);
   assign r_off     = 3'(mem_read1_addr - MMIO_BASE);
   assign reload_wr = wr_mmio && (w_off == MMIO_PIT_RELOAD);
   assign pend_wr   = wr_mmio && (w_off == MMIO_PENDING);

   // Nonblocking array update keeps both ports read-first on an address collision.
   always_ff @(posedge clk) begin
      if (wr_ram) begin
         for (int i = 0; i < 4; i++) begin
            if (mem_we[i]) ram[mem_write_addr[AW-1:0]][8*i +: 8] <= mem_write_data[8*i +: 8];
         end
      end
      ram_q0 <= ram[mem_read0_addr[AW-1:0]];
      if (mem_re) begin
         ram_q1  <= ram[mem_read1_addr[AW-1:0]];
         mmio_q1 <= mmio_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hit0      <= 1'b0;
         ram_hit1  <= 1'b0;
         mmio_hit1 <= 1'b0;
      end else begin
         hit0 <= in_ram(mem_read0_addr);
         if (mem_re) begin
            ram_hit1  <= in_ram(mem_read1_addr);
            mmio_hit1 <= in_mmio(mem_read1_addr);
         end
      end
   end

   assign mem_read0_data = hit0 ? ram_q0 : 32'b0;
   assign mem_read1_data = ram_hit1 ? ram_q1 : (mmio_hit1 ? mmio_q1 : 32'b0);

   always_comb begin
      status_word = '0;
      status_word[ST_EMPTY] = u_empty;
      status_word[ST_FULL]  = u_full;
      status_word[ST_BUSY]  = u_busy;
      status_word[ST_COUNT_LSB +: ST_COUNT_W] = u_count;
      status_word[ST_OVF]   = u_ovf;
   end

   always_comb begin
      mmio_rdata = '0;
      case (r_off)
         MMIO_TX:         mmio_rdata = '0;
         MMIO_STATUS:     mmio_rdata = status_word;
         MMIO_PIT_RELOAD: mmio_rdata = pit_reload;
         MMIO_PIT_COUNT:  mmio_rdata = pit_count;
         MMIO_PENDING:    mmio_rdata = {16'b0, interrupts};
         default:         mmio_rdata = '0;
      endcase
   end

   // A reload write in the expiry cycle restarts the period without raising pending[0].
   assign pit_fire = clk_en && (pit_reload != '0) && (pit_count == 32'd1) && !reload_wr;

   always_ff @(posedge clk) begin
      if (rst) begin
         pit_reload <= '0;
         pit_count  <= '0;
      end else if (reload_wr) begin
         pit_reload <= mem_write_data;
         pit_count  <= mem_write_data;
      end else if (clk_en && (pit_reload != '0)) begin
         pit_count <= (pit_count == 32'd1) ? pit_reload : pit_count - 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         irq_s1 <= '0;
         irq_s2 <= '0;
         pend0  <= 1'b0;
      end else begin
         irq_s1 <= ext_irq;
         irq_s2 <= irq_s1;
         if (pit_fire)                            pend0 <= 1'b1;
         else if (pend_wr && mem_write_data[0])   pend0 <= 1'b0;
      end
   end

   assign interrupts = {irq_s2, pend1, pend0};

`ifdef MEM_RESPONDER_UART_EN
   logic u_done;

   uart_tx_serializer #(
      .TX_DEPTH (TX_DEPTH),
      .BAUD_DIV (BAUD_DIV)
   ) u_ser (
      .clk       (clk),
      .rst       (rst),
      .push      (wr_mmio && (w_off == MMIO_TX)),
      .push_data (mem_write_data[7:0]),
      .clr_ovf   (wr_mmio && (w_off == MMIO_STATUS)),
      .tx        (uart_tx),
      .busy      (u_busy),
      .empty     (u_empty),
      .full      (u_full),
      .ovf       (u_ovf),
      .count     (u_count),
      .done      (u_done)
   );

   always_ff @(posedge clk) begin
      if (rst)                                 pend1 <= 1'b0;
      else if (u_done)                         pend1 <= 1'b1;
      else if (pend_wr && mem_write_data[1])   pend1 <= 1'b0;
   end
`else
   localparam int unused_cfg = TX_DEPTH + BAUD_DIV;

   assign uart_tx = 1'b1;
   assign pend1   = 1'b0;
   assign u_busy  = 1'b0;
   assign u_empty = 1'b0;
   assign u_full  = 1'b0;
   assign u_ovf   = 1'b0;
   assign u_count = '0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against a behavioural model.
module tb_mem_responder;

   localparam int          RAM_WORDS = 4096;
   localparam logic [17:0] MMIO_BASE = 18'h3FF00;
   localparam int          TX_DEPTH  = 4;
   localparam int          BAUD_DIV  = 4;
   localparam logic [17:0] A_TX      = MMIO_BASE;
   localparam logic [17:0] A_STATUS  = MMIO_BASE + 18'd1;
   localparam logic [17:0] A_RELOAD  = MMIO_BASE + 18'd2;
   localparam logic [17:0] A_COUNT   = MMIO_BASE + 18'd3;
   localparam logic [17:0] A_PENDING = MMIO_BASE + 18'd4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clk_en = 1'b1;
   logic [17:0] mem_read0_addr = '0;
   logic [31:0] mem_read0_data;
   logic        mem_re = 1'b0;
   logic [17:0] mem_read1_addr = '0;
   logic [31:0] mem_read1_data;
   logic [3:0]  mem_we = '0;
   logic [17:0] mem_write_addr = '0;
   logic [31:0] mem_write_data = '0;
   logic [13:0] ext_irq = '0;
   logic [15:0] interrupts;
   logic        uart_tx;

   int passed = 0;
   int total  = 0;
   bit [31:0] ram_m [int];

   mem_responder #(
      .RAM_WORDS (RAM_WORDS),
      .INIT_FILE (""),
      .MMIO_BASE (MMIO_BASE),
      .TX_DEPTH  (TX_DEPTH),
      .BAUD_DIV  (BAUD_DIV)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .clk_en         (clk_en),
      .mem_read0_addr (mem_read0_addr),
      .mem_read0_data (mem_read0_data),
      .mem_re         (mem_re),
      .mem_read1_addr (mem_read1_addr),
      .mem_read1_data (mem_read1_data),
      .mem_we         (mem_we),
      .mem_write_addr (mem_write_addr),
      .mem_write_data (mem_write_data),
      .ext_irq        (ext_irq),
      .interrupts     (interrupts),
      .uart_tx        (uart_tx)
   );

   always #5 clk = ~clk;

   function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] d, input bit [3:0] we);
      bit [31:0] r = old;
      for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   function automatic bit [31:0] mread(input int a);
      if (a < RAM_WORDS && ram_m.exists(a)) return ram_m[a];
      return 32'h0;
   endfunction

   function automatic logic frame_bit(input logic [7:0] b, input int k);
      int idx = k / BAUD_DIV;
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
      return 1'b1;
   endfunction

   function automatic logic [17:0] pick_addr();
      int r = $urandom_range(0, 7);
      if (r == 0) return 18'(RAM_WORDS + $urandom_range(0, 3));
      if (r == 1) return 18'h3F000;
      return 18'($urandom_range(0, 63));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [17:0] a, input logic [31:0] d, input logic [3:0] we);
      mem_write_addr = a;
      mem_write_data = d;
      mem_we         = we;
      clk_en         = 1'b1;
      tick();
      mem_we = '0;
      if (int'(a) < RAM_WORDS) ram_m[int'(a)] = merge(mread(int'(a)), d, we);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      mem_we = '0;
      mem_re = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      total++; if (mem_read0_data !== 32'h0) $display("FAIL reset_rd0: got %h want 0", mem_read0_data); else passed++;
      total++; if (mem_read1_data !== 32'h0) $display("FAIL reset_rd1: got %h want 0", mem_read1_data); else passed++;
      total++; if (interrupts !== 16'h0) $display("FAIL reset_irq: got %h want 0", interrupts); else passed++;
      total++; if (uart_tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", uart_tx); else passed++;
      rst = 1'b0;
   endtask

   task automatic test_byte_enable();
      do_write(18'h100, 32'hAABBCCDD, 4'b1111);
      do_write(18'h100, 32'h11223344, 4'b0101);
      mem_re = 1'b1;
      mem_read1_addr = 18'h100;
      mem_read0_addr = 18'h100;
      tick();
      mem_re = 1'b0;
      total++; if (mem_read1_data !== 32'hAA22CC44) $display("FAIL be_port1: got %h want AA22CC44", mem_read1_data); else passed++;
      total++; if (mem_read0_data !== 32'hAA22CC44) $display("FAIL be_port0: got %h want AA22CC44", mem_read0_data); else passed++;
   endtask

   task automatic test_read_first();
      do_write(18'h200, 32'h0, 4'b1111);
      mem_re = 1'b1;
      mem_read1_addr = 18'h200;
      mem_read0_addr = 18'h200;
      do_write(18'h200, 32'h5, 4'b1111);
      total++; if (mem_read1_data !== 32'h0) $display("FAIL rf_old1: got %h want 0", mem_read1_data); else passed++;
      total++; if (mem_read0_data !== 32'h0) $display("FAIL rf_old0: got %h want 0", mem_read0_data); else passed++;
      tick();
      total++; if (mem_read1_data !== 32'h5) $display("FAIL rf_new1: got %h want 5", mem_read1_data); else passed++;
      total++; if (mem_read0_data !== 32'h5) $display("FAIL rf_new0: got %h want 5", mem_read0_data); else passed++;
      clk_en = 1'b0;
      mem_write_addr = 18'h200;
      mem_write_data = 32'h77;
      mem_we = 4'b1111;
      tick();
      mem_we = '0;
      clk_en = 1'b1;
      tick();
      total++; if (mem_read1_data !== 32'h5) $display("FAIL gated_write: got %h want 5", mem_read1_data); else passed++;
      mem_re = 1'b0;
   endtask

   task automatic test_random_ram();
      bit [31:0] e0, e1;
      for (int a = 0; a < 64; a++) if (a != 'h100 && a != 'h200) do_write(18'(a), 32'h0, 4'b1111);
      mem_re = 1'b1;
      mem_read1_addr = 18'h0;
      tick();
      e1 = mread(0);
      for (int i = 0; i < 80; i++) begin
         logic [17:0] wa, ra0, ra1;
         logic [31:0] d;
         logic [3:0]  we;
         logic        ce, re;
         wa = pick_addr(); ra0 = pick_addr(); ra1 = pick_addr();
         d = $urandom; we = 4'($urandom_range(0, 15));
         ce = ($urandom_range(0, 3) != 0); re = ($urandom_range(0, 2) != 0);
         clk_en = ce; mem_we = we; mem_write_addr = wa; mem_write_data = d;
         mem_re = re; mem_read0_addr = ra0; mem_read1_addr = ra1;
         e0 = mread(int'(ra0));
         if (re) e1 = mread(int'(ra1));
         tick();
         total++; if (mem_read0_data !== e0) $display("FAIL rand_rd0 i=%0d: got %h want %h", i, mem_read0_data, e0); else passed++;
         total++; if (mem_read1_data !== e1) $display("FAIL rand_rd1 i=%0d: got %h want %h", i, mem_read1_data, e1); else passed++;
         if (ce && we != 0 && int'(wa) < RAM_WORDS) ram_m[int'(wa)] = merge(mread(int'(wa)), d, we);
      end
      mem_we = '0; mem_re = 1'b0; clk_en = 1'b1; mem_read0_addr = '0;
   endtask

   task automatic test_pit_directed();
      pulse_reset();
      do_write(A_RELOAD, 32'd3, 4'b1111);
      tick();
      tick();
      total++; if (interrupts[0] !== 1'b0) $display("FAIL pit_early: got %b want 0", interrupts[0]); else passed++;
      tick();
      total++; if (interrupts !== 16'h0001) $display("FAIL pit_fire: got %h want 0001", interrupts); else passed++;
      do_write(A_PENDING, 32'h1, 4'b0001);
      total++; if (interrupts[0] !== 1'b0) $display("FAIL pit_clear: got %b want 0", interrupts[0]); else passed++;
      tick();
      total++; if (interrupts[0] !== 1'b0) $display("FAIL pit_gap: got %b want 0", interrupts[0]); else passed++;
      tick();
      total++; if (interrupts[0] !== 1'b1) $display("FAIL pit_period: got %b want 1", interrupts[0]); else passed++;
      do_write(A_PENDING, 32'h1, 4'b1111);
      tick();
      do_write(A_RELOAD, 32'd5, 4'b1111);
      total++; if (interrupts[0] !== 1'b0) $display("FAIL pit_write_wins: got %b want 0", interrupts[0]); else passed++;
      mem_re = 1'b1;
      mem_read1_addr = A_COUNT;
      tick();
      mem_re = 1'b0;
      total++; if (mem_read1_data !== 32'd5) $display("FAIL pit_count_rd: got %0d want 5", mem_read1_data); else passed++;
      do_write(A_RELOAD, 32'd0, 4'b1111);
   endtask

   task automatic test_pit_random();
      bit [31:0] m_reload = 0, m_count = 0, exp_cnt;
      bit        m_pend = 0;
      pulse_reset();
      for (int i = 0; i < 120; i++) begin
         int        op = $urandom_range(0, 9);
         bit        ce = ($urandom_range(0, 3) != 0);
         bit [31:0] d;
         bit        wr_rl, clr, fire;
         clk_en = ce; mem_re = 1'b1; mem_read1_addr = A_COUNT;
         if (op == 0) begin
            d = $urandom_range(0, 4);
            mem_write_addr = A_RELOAD; mem_write_data = d; mem_we = 4'b1111;
         end else if (op == 1) begin
            d = $urandom;
            mem_write_addr = A_PENDING; mem_write_data = d; mem_we = 4'b0010;
         end else begin
            d = 0;
            mem_we = '0;
         end
         exp_cnt = m_count;
         tick();
         total++; if (mem_read1_data !== exp_cnt) $display("FAIL pitr_count i=%0d: got %0d want %0d", i, mem_read1_data, exp_cnt); else passed++;
         wr_rl = ce && op == 0;
         clr   = ce && op == 1 && d[0];
         fire  = ce && m_reload != 0 && m_count == 1;
         if (wr_rl) begin
            m_reload = d; m_count = d;
         end else if (ce && m_reload != 0) begin
            m_count = fire ? m_reload : m_count - 1;
         end
         if (fire && !wr_rl) m_pend = 1;
         else if (clr) m_pend = 0;
         total++; if (interrupts[0] !== m_pend) $display("FAIL pitr_pend i=%0d: got %b want %b", i, interrupts[0], m_pend); else passed++;
      end
      mem_we = '0; mem_re = 1'b0; clk_en = 1'b1;
      do_write(A_RELOAD, 32'd0, 4'b1111);
   endtask

   task automatic test_ext_irq();
      pulse_reset();
      ext_irq = 14'h0001;
      tick();
      total++; if (interrupts !== 16'h0) $display("FAIL irq_lag: got %h want 0000", interrupts); else passed++;
      tick();
      tick();
      total++; if (interrupts !== 16'h0004) $display("FAIL irq_sync: got %h want 0004", interrupts); else passed++;
      do_write(A_PENDING, 32'hFFFF, 4'b1111);
      total++; if (interrupts !== 16'h0004) $display("FAIL irq_noclear: got %h want 0004", interrupts); else passed++;
      mem_re = 1'b1;
      mem_read1_addr = A_PENDING;
      tick();
      mem_re = 1'b0;
      total++; if (mem_read1_data !== 32'h4) $display("FAIL irq_read: got %h want 00000004", mem_read1_data); else passed++;
      ext_irq = '0;
      tick(); tick(); tick();
      total++; if (interrupts !== 16'h0) $display("FAIL irq_drop: got %h want 0000", interrupts); else passed++;
   endtask

`ifdef MEM_RESPONDER_UART_EN
   task automatic test_uart();
      logic [7:0]  bytes [2];
      logic [31:0] exp;
      int          pushes = TX_DEPTH + 2;
      int          held;
      bit          ovf;
      pulse_reset();
      bytes[0] = 8'h55;
      bytes[1] = 8'($urandom);
      for (int n = 0; n < 2; n++) begin
         do_write(A_TX, {24'h0, bytes[n]}, 4'b0001);
         for (int k = 0; k < 10 * BAUD_DIV; k++) begin
            logic e;
            tick();
            e = frame_bit(bytes[n], k);
            total++; if (uart_tx !== e) $display("FAIL tx_bit b=%h k=%0d: got %b want %b", bytes[n], k, uart_tx, e); else passed++;
         end
         tick();
         total++; if (interrupts[1] !== 1'b1) $display("FAIL tx_done_irq: got %b want 1", interrupts[1]); else passed++;
         do_write(A_PENDING, 32'h2, 4'b1111);
         total++; if (interrupts[1] !== 1'b0) $display("FAIL tx_irq_clear: got %b want 0", interrupts[1]); else passed++;
      end
      // First byte leaves for the serializer at once; the rest queue behind a long frame.
      for (int i = 0; i < pushes; i++) begin
         mem_write_addr = A_TX; mem_write_data = i; mem_we = 4'b0001;
         tick();
      end
      mem_we = '0;
      held = (pushes - 1 > TX_DEPTH) ? TX_DEPTH : pushes - 1;
      ovf  = (pushes - 1 > TX_DEPTH);
      exp  = (32'(ovf) << 10) | (32'(held) << 3) | (32'h1 << 2) | (32'(held == TX_DEPTH) << 1) | 32'(held == 0);
      mem_re = 1'b1; mem_read1_addr = A_STATUS;
      tick();
      total++; if (mem_read1_data !== exp) $display("FAIL status_ovf: got %h want %h", mem_read1_data, exp); else passed++;
      mem_re = 1'b0;
      do_write(A_STATUS, 32'h0, 4'b1000);
      exp = exp & ~(32'h1 << 10);
      mem_re = 1'b1;
      tick();
      mem_re = 1'b0;
      total++; if (mem_read1_data !== exp) $display("FAIL status_clr: got %h want %h", mem_read1_data, exp); else passed++;
   endtask
`else
   task automatic test_uart();
      pulse_reset();
      do_write(A_TX, 32'h55, 4'b0001);
      for (int k = 0; k < 10 * BAUD_DIV + 2; k++) begin
         total++; if (uart_tx !== 1'b1) $display("FAIL tx_idle k=%0d: got %b want 1", k, uart_tx); else passed++;
         tick();
      end
      total++; if (interrupts[1] !== 1'b0) $display("FAIL tx_irq_off: got %b want 0", interrupts[1]); else passed++;
      mem_re = 1'b1; mem_read1_addr = A_STATUS;
      tick();
      mem_re = 1'b0;
      total++; if (mem_read1_data !== 32'h0) $display("FAIL status_off: got %h want 0", mem_read1_data); else passed++;
   endtask
`endif

   task automatic test_reset_mid_frame();
      bit [31:0] exp_status;
      bit [31:0] exp_ram;
`ifdef MEM_RESPONDER_UART_EN
      exp_status = 32'h1;
`else
      exp_status = 32'h0;
`endif
      pulse_reset();
      for (int i = 0; i < 3; i++) do_write(A_TX, 32'hA0 + i, 4'b0001);
      repeat (BAUD_DIV * 3) tick();
      rst = 1'b1;
      tick();
      total++; if (uart_tx !== 1'b1) $display("FAIL rst_tx: got %b want 1", uart_tx); else passed++;
      rst = 1'b0;
      mem_re = 1'b1; mem_read1_addr = A_STATUS;
      tick();
      total++; if (mem_read1_data !== exp_status) $display("FAIL rst_status: got %h want %h", mem_read1_data, exp_status); else passed++;
      mem_read1_addr = 18'h100;
      exp_ram = mread(32'h100);
      tick();
      mem_re = 1'b0;
      total++; if (mem_read1_data !== exp_ram) $display("FAIL rst_ram: got %h want %h", mem_read1_data, exp_ram); else passed++;
   endtask

   initial begin
      test_reset();
      test_byte_enable();
      test_read_first();
      test_random_ram();
      test_pit_directed();
      test_pit_random();
      test_ext_irq();
      test_uart();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
